// File: rtl/wb_regfile_if.sv
// Bundles the writeback-stage inputs, the decode-stage read ports and the
// observable writeback outputs of the register file into one port group.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write_w;
  logic                  mem_to_reg_w;
  logic [DATA_WIDTH-1:0] alu_result_w;
  logic [DATA_WIDTH-1:0] write_data_w;
  logic [ADDR_WIDTH-1:0] write_reg_w;
  logic [ADDR_WIDTH-1:0] a1_d;
  logic [ADDR_WIDTH-1:0] a2_d;
  logic [DATA_WIDTH-1:0] rd1_d;
  logic [DATA_WIDTH-1:0] rd2_d;
  logic [DATA_WIDTH-1:0] result_w;
  logic [31:0]           wb_count;

  modport master (
    output reg_write_w, mem_to_reg_w, alu_result_w, write_data_w, write_reg_w,
    output a1_d, a2_d,
    input  rd1_d, rd2_d, result_w, wb_count
  );

  modport slave (
    input  reg_write_w, mem_to_reg_w, alu_result_w, write_data_w, write_reg_w,
    input  a1_d, a2_d,
    output rd1_d, rd2_d, result_w, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it, and serves two decode read ports with optional write-to-read bypass.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [31:0]           wb_count_q;
  logic [31:0]           wb_count_d;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  commit_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s [2];
  logic [DATA_WIDTH-1:0] rd_data_s [2];

  // Writeback value select and next-state of the register array and commit counter.
  always_comb begin
    result_s   = bus.mem_to_reg_w ? bus.write_data_w : bus.alu_result_w;
    // Reset wins over a same-cycle commit; index 0 is hardwired and never counted.
    commit_s   = ~reset & bus.reg_write_w & (bus.write_reg_w != {ADDR_WIDTH{1'b0}});
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (commit_s) begin
      regs_d[bus.write_reg_w] = result_s;
      wb_count_d              = wb_count_q + 32'd1;
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // Combinational read ports; a pending write is forwarded unless reset is active.
  always_comb begin
    rd_addr_s[0] = bus.a1_d;
    rd_addr_s[1] = bus.a2_d;
    rd_data_s[0] = {DATA_WIDTH{1'b0}};
    rd_data_s[1] = {DATA_WIDTH{1'b0}};
    for (int p = 0; p < 2; p++) begin
      if (rd_addr_s[p] == {ADDR_WIDTH{1'b0}}) begin
        rd_data_s[p] = {DATA_WIDTH{1'b0}};
      end else if (BYPASS && !reset && bus.reg_write_w &&
                   (bus.write_reg_w == rd_addr_s[p])) begin
        rd_data_s[p] = result_s;
      end else begin
        rd_data_s[p] = regs_q[rd_addr_s[p]];
      end
    end
  end

  // State update: synchronous clear of every entry and the counter, else commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wb_count_q <= 32'd0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign bus.rd1_d    = rd_data_s[0];
  assign bus.rd2_d    = rd_data_s[1];
  assign bus.result_w = result_s;
  assign bus.wb_count = wb_count_q;
endmodule
